// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing decoder.
// Recovers per-pixel row/col from active-low hs/vs and active-high blank_n,
// and tracks lock against an H_ACTIVE x V_ACTIVE raster.
// Optional feature macro: VS_WATCHDOG_EN (drops lock when vs stops toggling).
// All outputs are registered and follow the inputs by one clock.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
`ifdef VS_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 840000
`endif
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank_n,
  output logic [8:0] row,
  output logic [9:0] col,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_MAX  = 10'(H_ACTIVE);
  localparam logic [8:0] V_MAX  = 9'(V_ACTIVE);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] good_cnt, good_nx;
  logic       prev_hs, prev_vs, prev_blank;
  logic [9:0] pix_cnt, pix_cur, pix_nx;
  logic [8:0] line_cnt, line_cur, line_nx;
  logic       frame_bad, frame_bad_nx;
  logic       hs_fall, vs_fall, blank_fall;
  logic       overflow, line_bad, frame_good;
  logic       err_inc;
  logic       wdog_hit;

  // Edge detection, per-line/per-frame counter next values and raster error flags.
  always_comb begin
    hs_fall    = prev_hs & ~hs;
    vs_fall    = prev_vs & ~vs;
    blank_fall = prev_blank & ~blank_n;

    // hs/vs falling edges restart the counters in the very cycle they occur
    if (hs_fall) begin
      pix_cur = 10'd0;
    end else begin
      pix_cur = pix_cnt;
    end
    if (vs_fall) begin
      line_cur = 9'd0;
    end else begin
      line_cur = line_cnt;
    end

    overflow   = blank_n & (pix_cur == H_MAX);
    line_bad   = blank_fall & (pix_cnt != H_MAX);
    frame_good = ~frame_bad & (line_cnt == V_MAX);

    if (!blank_n) begin
      pix_nx = pix_cur;
    end else if (overflow) begin
      pix_nx = H_MAX;
    end else begin
      pix_nx = pix_cur + 10'd1;
    end

    if (vs_fall) begin
      line_nx = 9'd0;
    end else if (blank_fall && (line_cnt != 9'h1FF)) begin
      line_nx = line_cnt + 9'd1;
    end else begin
      line_nx = line_cnt;
    end

    // a frame's error history ends at vs_fall; an overflow in that cycle belongs to the new frame
    if (vs_fall) begin
      frame_bad_nx = overflow;
    end else begin
      frame_bad_nx = frame_bad | overflow | line_bad;
    end
  end

`ifdef VS_WATCHDOG_EN
  localparam logic [19:0] WDOG_MAX = 20'(WDOG_CYCLES);
  logic [19:0] wdog_cnt;

  assign wdog_hit = (wdog_cnt >= WDOG_MAX);

  // Watchdog: clocks since the last vs falling edge, saturating, cleared when it fires.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      wdog_cnt <= 20'd0;
    end else if (vs_fall || (wdog_hit && (state != ST_SEARCH))) begin
      wdog_cnt <= 20'd0;
    end else if (wdog_cnt != 20'hFFFFF) begin
      wdog_cnt <= wdog_cnt + 20'd1;
    end else begin
      wdog_cnt <= wdog_cnt;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Lock FSM next-state: partial first frame is skipped, LOCK_FRAMES good frames lock.
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_inc  = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_nx = ST_MEASURE;
          good_nx  = 4'd0;
        end else begin
          state_nx = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (frame_good) begin
            if ((good_cnt + 4'd1) == LOCK_N) begin
              state_nx = ST_LOCKED;
              good_nx  = 4'd0;
            end else begin
              good_nx = good_cnt + 4'd1;
            end
          end else begin
            good_nx = 4'd0;
          end
        end else if (wdog_hit) begin
          state_nx = ST_SEARCH;
          good_nx  = 4'd0;
        end else begin
          state_nx = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        // overflow drops lock at once; the rest of that frame is not judged again
        if (overflow) begin
          state_nx = ST_SEARCH;
          err_inc  = 1'b1;
        end else if (vs_fall) begin
          if (!frame_good) begin
            state_nx = ST_SEARCH;
            err_inc  = 1'b1;
          end else begin
            state_nx = ST_LOCKED;
          end
        end else if (wdog_hit) begin
          state_nx = ST_SEARCH;
          err_inc  = 1'b1;
        end else begin
          state_nx = ST_LOCKED;
        end
      end
      default: begin
        state_nx = ST_SEARCH;
        good_nx  = 4'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state    <= ST_SEARCH;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  // Input history and raster counters.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      prev_hs    <= 1'b1;
      prev_vs    <= 1'b1;
      prev_blank <= 1'b0;
      pix_cnt    <= 10'd0;
      line_cnt   <= 9'd0;
      frame_bad  <= 1'b0;
    end else begin
      prev_hs    <= hs;
      prev_vs    <= vs;
      prev_blank <= blank_n;
      pix_cnt    <= pix_nx;
      line_cnt   <= line_nx;
      frame_bad  <= frame_bad_nx;
    end
  end

  // Registered outputs: coordinates of the sampled pixel, status and error counter.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      row         <= 9'd0;
      col         <= 10'd0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      row         <= line_cur;
      col         <= pix_cur;
      pix_valid   <= blank_n & locked;
      frame_start <= vs_fall;
      locked      <= (state_nx == ST_LOCKED);
      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: table-driven bench for vga_sync_decoder on a reduced raster
// (4x3 active, 8x6 total) so that hundreds of frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HA  = 4;
  localparam int HFP = 2;
  localparam int HSW = 1;
  localparam int HT  = 8;
  localparam int VA  = 3;
  localparam int VFP = 1;
  localparam int VSW = 1;
  localparam int VBP = 1;
`ifdef VS_WATCHDOG_EN
  localparam int WDOG = 200;
`endif

  logic       clk = 1'b0;
  logic       reset, hs, vs, blank_n;
  logic [8:0] row;
  logic [9:0] col;
  logic       pix_valid, frame_start, locked;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .LOCK_FRAMES(2)
`ifdef VS_WATCHDOG_EN
    ,
    .WDOG_CYCLES(WDOG)
`endif
  ) dut (
    .vga_clk(clk),
    .reset(reset),
    .hs(hs),
    .vs(vs),
    .blank_n(blank_n),
    .row(row),
    .col(col),
    .pix_valid(pix_valid),
    .frame_start(frame_start),
    .locked(locked),
    .err_count(err_count)
  );

  typedef struct {
    string name;
    int    n_lines;      // active lines in this frame
    int    ovf_line;     // line carrying HA+1 pixels, -1 none
    int    short_line;   // line carrying HA-1 pixels, -1 none
    int    reset_at;     // cycle index of a 1-cycle reset pulse, -1 none
    int    exp_vsf_lock; // locked one cycle after vs_fall, -1 unchecked
    int    exp_lock;     // locked at end of frame
    int    exp_err;      // err_count at end of frame
    bit    pix_chk;      // check the full pix_valid/row/col sequence
  } frame_t;

  frame_t tbl[20];

  function automatic frame_t mk(input string nm, input int nl, input int ovf, input int sh,
                                input int rst, input int vl, input int el, input int ee,
                                input bit pc);
    frame_t f;
    f.name = nm; f.n_lines = nl; f.ovf_line = ovf; f.short_line = sh; f.reset_at = rst;
    f.exp_vsf_lock = vl; f.exp_lock = el; f.exp_err = ee; f.pix_chk = pc;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drives one frame cycle by cycle at negedge; outputs of the previous cycle are sampled first.
  task automatic drive_frame(input frame_t f);
    int total;
    int vsf_idx;
    int ovf_idx;
    int pv;
    int ln;
    int c;
    int width;
    total   = (f.n_lines + VFP + VSW + VBP) * HT;
    vsf_idx = (f.n_lines + VFP) * HT;
    ovf_idx = (f.ovf_line >= 0) ? (f.ovf_line * HT + HA) : -1;
    pv      = 0;
    for (int i = 0; i <= total; i++) begin
      @(negedge clk);
      if (i == vsf_idx + 1) begin
        chk({f.name, "_fs_pulse"}, frame_start, 1);
        if (f.exp_vsf_lock >= 0) chk({f.name, "_vsf_lock"}, locked, f.exp_vsf_lock);
      end
      if (i == vsf_idx + 2) chk({f.name, "_fs_end"}, frame_start, 0);
      if (ovf_idx >= 0 && i == ovf_idx)     chk({f.name, "_pre_ovf_lock"}, locked, 1);
      if (ovf_idx >= 0 && i == ovf_idx + 1) chk({f.name, "_ovf_lock"}, locked, 0);
      if (f.reset_at >= 0 && i == f.reset_at + 1) begin
        chk({f.name, "_rst_row"}, row, 0);
        chk({f.name, "_rst_col"}, col, 0);
        chk({f.name, "_rst_pv"}, pix_valid, 0);
        chk({f.name, "_rst_fs"}, frame_start, 0);
        chk({f.name, "_rst_lock"}, locked, 0);
        chk({f.name, "_rst_err"}, err_count, 0);
      end
      if (f.pix_chk && pix_valid) begin
        chk({f.name, "_row"}, row, pv / HA);
        chk({f.name, "_col"}, col, pv % HA);
        pv++;
      end
      reset = (i == f.reset_at);
      if (i < total) begin
        ln = i / HT;
        c  = i % HT;
        if (ln == f.ovf_line)        width = HA + 1;
        else if (ln == f.short_line) width = HA - 1;
        else                         width = HA;
        blank_n = (ln < f.n_lines) && (c < width);
        hs      = !((c >= HA + HFP) && (c < HA + HFP + HSW));
        vs      = !((ln >= f.n_lines + VFP) && (ln < f.n_lines + VFP + VSW));
      end else begin
        blank_n = 1'b0;
        hs      = 1'b1;
        vs      = 1'b1;
      end
    end
    if (f.pix_chk) chk({f.name, "_pix_count"}, pv, HA * VA);
    chk({f.name, "_locked"}, locked, f.exp_lock);
    chk({f.name, "_err"}, err_count, f.exp_err);
  endtask

  initial begin
    tbl[0]  = mk("f0_search",   VA, -1, -1, -1, 0, 0, 0, 1'b0);
    tbl[1]  = mk("f1_good1",    VA, -1, -1, -1, 0, 0, 0, 1'b0);
    tbl[2]  = mk("f2_lock",     VA, -1, -1, -1, 1, 1, 0, 1'b0);
    tbl[3]  = mk("f3_pixels",   VA, -1, -1, -1, 1, 1, 0, 1'b1);
    tbl[4]  = mk("f4_ovf",      VA,  1, -1, -1, 0, 0, 1, 1'b0);
    tbl[5]  = mk("f5_good1",    VA, -1, -1, -1, 0, 0, 1, 1'b0);
    tbl[6]  = mk("f6_relock",   VA, -1, -1, -1, 1, 1, 1, 1'b0);
    tbl[7]  = mk("f7_pixels",   VA, -1, -1, -1, 1, 1, 1, 1'b1);
    tbl[8]  = mk("f8_shortfr",  VA - 1, -1, -1, -1, 0, 0, 2, 1'b0);
    tbl[9]  = mk("f9_search",   VA, -1, -1, -1, 0, 0, 2, 1'b0);
    tbl[10] = mk("f10_good1",   VA, -1, -1, -1, 0, 0, 2, 1'b0);
    tbl[11] = mk("f11_relock",  VA, -1, -1, -1, 1, 1, 2, 1'b0);
    tbl[12] = mk("f12_shortln", VA, -1,  1, -1, 0, 0, 3, 1'b0);
    tbl[13] = mk("f13_search",  VA, -1, -1, -1, 0, 0, 3, 1'b0);
    tbl[14] = mk("f14_good1",   VA, -1, -1, -1, 0, 0, 3, 1'b0);
    tbl[15] = mk("f15_relock",  VA, -1, -1, -1, 1, 1, 3, 1'b0);
    tbl[16] = mk("f16_reset",   VA, -1, -1, 10, 0, 0, 0, 1'b0);
    tbl[17] = mk("f17_good1",   VA, -1, -1, -1, 0, 0, 0, 1'b0);
    tbl[18] = mk("f18_relock",  VA, -1, -1, -1, 1, 1, 0, 1'b0);
    tbl[19] = mk("f19_pixels",  VA, -1, -1, -1, 1, 1, 0, 1'b1);

    // power-on reset
    reset = 1'b1; hs = 1'b1; vs = 1'b1; blank_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;

    for (int k = 0; k < 20; k++) drive_frame(tbl[k]);

    // vs held high while locked: watchdog build drops lock, default build keeps it
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hs      = !(((i % HT) >= HA + HFP) && ((i % HT) < HA + HFP + HSW));
      vs      = 1'b1;
      blank_n = 1'b0;
    end
    @(negedge clk);
`ifdef VS_WATCHDOG_EN
    chk("wdog_locked", locked, 0);
    chk("wdog_err", err_count, 1);
`else
    chk("nowdog_locked", locked, 1);
    chk("nowdog_err", err_count, 0);
`endif

    // error counter saturation over 300 lock-loss events
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_frame(mk("sat_search", VA, -1, -1, -1, -1, 0, 0, 1'b0));
    drive_frame(mk("sat_good1",  VA, -1, -1, -1, -1, 0, 0, 1'b0));
    drive_frame(mk("sat_lock",   VA, -1, -1, -1, -1, 1, 0, 1'b0));
    for (int k = 1; k <= 300; k++) begin
      drive_frame(mk("sat_ovf",    VA,  1, -1, -1, -1, 0, (k > 255) ? 255 : k, 1'b0));
      drive_frame(mk("sat_good1",  VA, -1, -1, -1, -1, 0, (k > 255) ? 255 : k, 1'b0));
      drive_frame(mk("sat_relock", VA, -1, -1, -1, -1, 1, (k > 255) ? 255 : k, 1'b0));
    end
    chk("sat_final_err", err_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
